byte_lane_packer: RTL and testbench

Parametrised successor to the two-lane byte demux in the PHY receive path. It accepts a byte stream from the serial-to-parallel stage on one clock. It packs RATIO consecutive bytes into one word and hands successive words to LANES output lanes in round-robin order. Each lane has its own valid/ready holding register, with overrun detection, a frame-sync realignment input and an optional idle flush.

---
 rtl/byte_lane_packer.sv | 195 +++++++++++++++++++
 tb/tb_byte_lane_packer.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/byte_lane_packer.sv
// ---------------------------------------------------------------------------
// byte_lane_packer
//   Packs RATIO consecutive IN_W-bit symbols (MSB-first) into WW-bit words and
//   distributes successive words round-robin across LANES output lanes, each
//   with its own valid/ready holding register.
//
//   Optional feature macro: BYTE_LANE_PACKER_FLUSH_EN
//     Defined   : a partial word idle for IDLE_MAX cycles is zero-padded and
//                 emitted, with lane_partial set for that lane.
//     Undefined : partial words are held until completed, discarded by
//                 sync_in, or cleared by reset; lane_partial stays 0.
//
// Ports
//   clk_4f       in   block clock, rising edge
//   reset        in   asynchronous active-low reset
//   data_in      in   IN_W   input symbol
//   valid_in     in   1      data_in valid
//   sync_in      in   1      (with valid_in) symbol starts a new word/frame
//   lane_ready   in   LANES  per-lane consumer ready
//   lane_data    out  LANES*WW, lane i at [i*WW +: WW]
//   lane_valid   out  LANES  lane holds an unconsumed word
//   lane_partial out  LANES  lane word was zero-padded by flush
//   overrun      out  1      pulse: completed word dropped (target lane full)
//   sym_cnt      out  IDXW   symbols currently held in the packing buffer
// ---------------------------------------------------------------------------
module byte_lane_packer #(
  parameter  int unsigned IN_W     = 8,
  parameter  int unsigned RATIO    = 2,
  parameter  int unsigned LANES    = 2,
  parameter  int unsigned IDLE_MAX = 4,
  localparam int unsigned WW       = IN_W * RATIO,
  localparam int unsigned IDXW     = (RATIO > 1) ? $clog2(RATIO) : 1
) (
  input  logic                  clk_4f,
  input  logic                  reset,
  input  logic [IN_W-1:0]       data_in,
  input  logic                  valid_in,
  input  logic                  sync_in,
  input  logic [LANES-1:0]      lane_ready,
  output logic [LANES*WW-1:0]   lane_data,
  output logic [LANES-1:0]      lane_valid,
  output logic [LANES-1:0]      lane_partial,
  output logic                  overrun,
  output logic [IDXW-1:0]       sym_cnt
);

  localparam int unsigned LPW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(RATIO - 1);
  localparam logic [LPW-1:0]  LP_LAST  = LPW'(LANES - 1);

  // State registers
  logic [WW-1:0]        r_buf;
  logic [IDXW-1:0]      r_idx;
  logic [LPW-1:0]       r_lp;
  logic [LANES*WW-1:0]  r_lane_data;
  logic [LANES-1:0]     r_lane_valid;
  logic [LANES-1:0]     r_lane_partial;
  logic                 r_overrun;

  // Next-state values
  logic [WW-1:0]        w_buf;
  logic [IDXW-1:0]      w_idx;
  logic [LPW-1:0]       w_lp;
  logic [LANES*WW-1:0]  w_lane_data;
  logic [LANES-1:0]     w_lane_valid;
  logic [LANES-1:0]     w_lane_partial;
  logic                 w_overrun;

  // Completion bookkeeping
  logic [IDXW-1:0]      w_slot;
  logic [LPW-1:0]       w_sel;
  logic [WW-1:0]        w_word;
  logic                 w_offer;
  logic                 w_flush;

`ifdef BYTE_LANE_PACKER_FLUSH_EN
  localparam int unsigned CW = $clog2(IDLE_MAX + 1);
  logic [CW-1:0]        r_idle;
  logic [CW-1:0]        w_idle;
`endif

  // Next-state: packing, completion, lane load/overrun, consumption
  always_comb begin
    w_buf          = r_buf;
    w_idx          = r_idx;
    w_lp           = r_lp;
    w_lane_data    = r_lane_data;
    // Consumption: a ready lane clears unless reloaded below at the same edge
    w_lane_valid   = r_lane_valid & ~lane_ready;
    w_lane_partial = r_lane_partial;
    w_overrun      = 1'b0;
    w_slot         = '0;
    w_sel          = r_lp;
    w_word         = '0;
    w_offer        = 1'b0;
    w_flush        = 1'b0;
`ifdef BYTE_LANE_PACKER_FLUSH_EN
    w_idle         = r_idle;
`endif

    if (valid_in) begin
      // sync_in restarts the word and the lane rotation
      w_slot = sync_in ? '0 : r_idx;
      w_sel  = sync_in ? '0 : r_lp;
      // Starting a word clears the buffer so unfilled LSBs read as zero
      w_buf  = (w_slot == '0) ? '0 : r_buf;
      for (int s = 0; s < int'(RATIO); s++) begin
        if (w_slot == IDXW'(s)) begin
          w_buf[WW-1-s*IN_W -: IN_W] = data_in;
        end
      end
      if (sync_in) begin
        w_lp = '0;
      end
      if (w_slot == IDX_LAST) begin
        w_offer = 1'b1;
        w_word  = w_buf;
        w_idx   = '0;
      end else begin
        w_idx   = w_slot + IDXW'(1);
      end
`ifdef BYTE_LANE_PACKER_FLUSH_EN
      w_idle = '0;
`endif
    end
`ifdef BYTE_LANE_PACKER_FLUSH_EN
    else if ((r_idx != '0) && (r_idle < CW'(IDLE_MAX))) begin
      w_idle = r_idle + CW'(1);
      // Idle limit reached: emit the left-aligned partial word
      if (r_idle == CW'(IDLE_MAX - 1)) begin
        w_offer = 1'b1;
        w_flush = 1'b1;
        w_word  = r_buf;
        w_sel   = r_lp;
        w_idx   = '0;
      end
    end
`endif

    if (w_offer) begin
      for (int i = 0; i < int'(LANES); i++) begin
        if (w_sel == LPW'(i)) begin
          if (r_lane_valid[i] && !lane_ready[i]) begin
            w_overrun = 1'b1;
          end else begin
            w_lane_valid[i]          = 1'b1;
            w_lane_partial[i]        = w_flush;
            w_lane_data[i*WW +: WW]  = w_word;
          end
        end
      end
      // Pointer advances even on a drop to keep later words lane-aligned
      w_lp = (w_sel == LP_LAST) ? '0 : w_sel + LPW'(1);
    end
  end

  // State register
  always_ff @(posedge clk_4f or negedge reset) begin
    if (!reset) begin
      r_buf          <= '0;
      r_idx          <= '0;
      r_lp           <= '0;
      r_lane_data    <= '0;
      r_lane_valid   <= '0;
      r_lane_partial <= '0;
      r_overrun      <= 1'b0;
    end else begin
      r_buf          <= w_buf;
      r_idx          <= w_idx;
      r_lp           <= w_lp;
      r_lane_data    <= w_lane_data;
      r_lane_valid   <= w_lane_valid;
      r_lane_partial <= w_lane_partial;
      r_overrun      <= w_overrun;
    end
  end

`ifdef BYTE_LANE_PACKER_FLUSH_EN
  // Idle counter
  always_ff @(posedge clk_4f or negedge reset) begin
    if (!reset) begin
      r_idle <= '0;
    end else begin
      r_idle <= w_idle;
    end
  end
`endif

  assign lane_data    = r_lane_data;
  assign lane_valid   = r_lane_valid;
  assign lane_partial = r_lane_partial;
  assign overrun      = r_overrun;
  assign sym_cnt      = r_idx;

endmodule

// File: tb/tb_byte_lane_packer.sv
// ---------------------------------------------------------------------------
// tb_byte_lane_packer
//   Directed self-checking bench. u_dut uses default parameters
//   (IN_W=8, RATIO=2, LANES=2, IDLE_MAX=4); u_dut1 is a single-lane build
//   used for the same-edge consume/load scenario.
// ---------------------------------------------------------------------------
module tb_byte_lane_packer;

  logic        clk_4f = 1'b0;
  logic        reset  = 1'b0;
  logic [7:0]  data_in;
  logic        valid_in;
  logic        sync_in;
  logic [1:0]  lane_ready;
  logic [31:0] lane_data;
  logic [1:0]  lane_valid;
  logic [1:0]  lane_partial;
  logic        overrun;
  logic [0:0]  sym_cnt;

  logic [7:0]  d1_data;
  logic        d1_valid;
  logic        d1_sync;
  logic [0:0]  d1_ready;
  logic [15:0] d1_lane_data;
  logic [0:0]  d1_lane_valid;
  logic [0:0]  d1_lane_partial;
  logic        d1_overrun;
  logic [0:0]  d1_sym_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk_4f = ~clk_4f;

  byte_lane_packer u_dut (
    .clk_4f       (clk_4f),
    .reset        (reset),
    .data_in      (data_in),
    .valid_in     (valid_in),
    .sync_in      (sync_in),
    .lane_ready   (lane_ready),
    .lane_data    (lane_data),
    .lane_valid   (lane_valid),
    .lane_partial (lane_partial),
    .overrun      (overrun),
    .sym_cnt      (sym_cnt)
  );

  byte_lane_packer #(.LANES(1)) u_dut1 (
    .clk_4f       (clk_4f),
    .reset        (reset),
    .data_in      (d1_data),
    .valid_in     (d1_valid),
    .sync_in      (d1_sync),
    .lane_ready   (d1_ready),
    .lane_data    (d1_lane_data),
    .lane_valid   (d1_lane_valid),
    .lane_partial (d1_lane_partial),
    .overrun      (d1_overrun),
    .sym_cnt      (d1_sym_cnt)
  );

  // Drive one cycle on u_dut from a negedge; returns at the following negedge
  task automatic drive(input logic [7:0] d, input logic v, input logic s,
                       input logic [1:0] rdy);
    data_in = d; valid_in = v; sync_in = s; lane_ready = rdy;
    @(posedge clk_4f);
    @(negedge clk_4f);
  endtask

  task automatic drive1(input logic [7:0] d, input logic v, input logic rdy);
    d1_data = d; d1_valid = v; d1_sync = 1'b0; d1_ready = rdy;
    @(posedge clk_4f);
    @(negedge clk_4f);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (6) begin
      data_in    = 8'($urandom);
      valid_in   = 1'($urandom);
      sync_in    = 1'($urandom);
      lane_ready = 2'($urandom);
      @(negedge clk_4f);
    end
    checks++;
    if ({lane_data, lane_valid, lane_partial, overrun, sym_cnt} !== 38'd0) begin
      failures++;
      $display("FAIL reset_outputs: got data=%h v=%b p=%b ovr=%b cnt=%h want all 0",
               lane_data, lane_valid, lane_partial, overrun, sym_cnt);
    end
    checks++;
    if ({d1_lane_data, d1_lane_valid, d1_overrun, d1_sym_cnt} !== 19'd0) begin
      failures++;
      $display("FAIL reset_outputs_1lane: got data=%h v=%b want 0", d1_lane_data, d1_lane_valid);
    end
    data_in = 8'h00; valid_in = 1'b0; sync_in = 1'b0; lane_ready = 2'b00;
    reset = 1'b1;
  endtask

  task automatic test_basic;
    drive(8'hA1, 1'b1, 1'b0, 2'b11);
    checks++;
    if (lane_valid !== 2'b00 || sym_cnt !== 1'b1) begin
      failures++;
      $display("FAIL basic_first_byte: got v=%b cnt=%h want v=00 cnt=1", lane_valid, sym_cnt);
    end
    drive(8'hB2, 1'b1, 1'b0, 2'b11);
    checks++;
    if (lane_valid !== 2'b01 || lane_data[15:0] !== 16'hA1B2 || sym_cnt !== 1'b0) begin
      failures++;
      $display("FAIL basic_word0: got v=%b d0=%h cnt=%h want v=01 d0=a1b2 cnt=0",
               lane_valid, lane_data[15:0], sym_cnt);
    end
    drive(8'hC3, 1'b1, 1'b0, 2'b11);
    checks++;
    if (lane_valid !== 2'b00) begin
      failures++;
      $display("FAIL basic_consume0: got v=%b want 00", lane_valid);
    end
    drive(8'hD4, 1'b1, 1'b0, 2'b11);
    checks++;
    if (lane_valid !== 2'b10 || lane_data[31:16] !== 16'hC3D4) begin
      failures++;
      $display("FAIL basic_word1: got v=%b d1=%h want v=10 d1=c3d4", lane_valid, lane_data[31:16]);
    end
    drive(8'h00, 1'b0, 1'b0, 2'b11);
    checks++;
    if (lane_valid !== 2'b00 || overrun !== 1'b0) begin
      failures++;
      $display("FAIL basic_drain: got v=%b ovr=%b want v=00 ovr=0", lane_valid, overrun);
    end
  endtask

  task automatic test_overrun;
    for (int b = 1; b <= 5; b++) begin
      drive(8'(b), 1'b1, 1'b0, 2'b00);
      checks++;
      if (overrun !== 1'b0) begin
        failures++;
        $display("FAIL ovr_quiet_b%0d: got %b want 0", b, overrun);
      end
    end
    checks++;
    if (lane_valid !== 2'b11 || lane_data !== 32'h0304_0102) begin
      failures++;
      $display("FAIL ovr_fill: got v=%b data=%h want v=11 data=03040102", lane_valid, lane_data);
    end
    drive(8'h06, 1'b1, 1'b0, 2'b00);
    checks++;
    if (overrun !== 1'b1 || lane_data[15:0] !== 16'h0102) begin
      failures++;
      $display("FAIL ovr_first: got ovr=%b d0=%h want ovr=1 d0=0102", overrun, lane_data[15:0]);
    end
    drive(8'h07, 1'b1, 1'b0, 2'b00);
    checks++;
    if (overrun !== 1'b0) begin
      failures++;
      $display("FAIL ovr_pulse_width: got %b want 0", overrun);
    end
    drive(8'h08, 1'b1, 1'b0, 2'b00);
    checks++;
    if (overrun !== 1'b1 || lane_data[31:16] !== 16'h0304 || lane_valid !== 2'b11) begin
      failures++;
      $display("FAIL ovr_second: got ovr=%b d1=%h v=%b want ovr=1 d1=0304 v=11",
               overrun, lane_data[31:16], lane_valid);
    end
    drive(8'h00, 1'b0, 1'b0, 2'b11);
    checks++;
    if (lane_valid !== 2'b00 || overrun !== 1'b0) begin
      failures++;
      $display("FAIL ovr_drain: got v=%b ovr=%b want v=00 ovr=0", lane_valid, overrun);
    end
  endtask

  task automatic test_sync;
    // Leave the lane pointer at 1 before realigning
    drive(8'h99, 1'b1, 1'b0, 2'b11);
    drive(8'h88, 1'b1, 1'b0, 2'b11);
    checks++;
    if (lane_valid !== 2'b01 || lane_data[15:0] !== 16'h9988) begin
      failures++;
      $display("FAIL sync_pre: got v=%b d0=%h want v=01 d0=9988", lane_valid, lane_data[15:0]);
    end
    drive(8'h11, 1'b1, 1'b0, 2'b11);
    drive(8'h22, 1'b1, 1'b1, 2'b11);
    checks++;
    if (sym_cnt !== 1'b1 || overrun !== 1'b0 || lane_valid !== 2'b00) begin
      failures++;
      $display("FAIL sync_discard: got cnt=%h ovr=%b v=%b want cnt=1 ovr=0 v=00",
               sym_cnt, overrun, lane_valid);
    end
    drive(8'h33, 1'b1, 1'b0, 2'b11);
    checks++;
    if (lane_valid !== 2'b01 || lane_data[15:0] !== 16'h2233 || overrun !== 1'b0) begin
      failures++;
      $display("FAIL sync_word: got v=%b d0=%h ovr=%b want v=01 d0=2233 ovr=0",
               lane_valid, lane_data[15:0], overrun);
    end
    drive(8'h00, 1'b0, 1'b0, 2'b11);
  endtask

  task automatic test_flush;
    drive(8'hEE, 1'b1, 1'b1, 2'b00);
    repeat (3) drive(8'h00, 1'b0, 1'b0, 2'b00);
    checks++;
    if (lane_valid !== 2'b00 || sym_cnt !== 1'b1) begin
      failures++;
      $display("FAIL flush_wait: got v=%b cnt=%h want v=00 cnt=1", lane_valid, sym_cnt);
    end
    drive(8'h00, 1'b0, 1'b0, 2'b00);
`ifdef BYTE_LANE_PACKER_FLUSH_EN
    checks++;
    if (lane_valid !== 2'b01 || lane_data[15:0] !== 16'hEE00 || lane_partial !== 2'b01 ||
        sym_cnt !== 1'b0) begin
      failures++;
      $display("FAIL flush_emit: got v=%b d0=%h p=%b cnt=%h want v=01 d0=ee00 p=01 cnt=0",
               lane_valid, lane_data[15:0], lane_partial, sym_cnt);
    end
    drive(8'h00, 1'b0, 1'b0, 2'b11);
`else
    checks++;
    if (lane_valid !== 2'b00 || sym_cnt !== 1'b1 || lane_partial !== 2'b00) begin
      failures++;
      $display("FAIL flush_absent: got v=%b cnt=%h p=%b want v=00 cnt=1 p=00",
               lane_valid, sym_cnt, lane_partial);
    end
`endif
  endtask

  task automatic test_async_reset;
    drive(8'h12, 1'b1, 1'b1, 2'b00);
    drive(8'h34, 1'b1, 1'b0, 2'b00);
    drive(8'h56, 1'b1, 1'b0, 2'b00);
    checks++;
    if (lane_valid !== 2'b01 || lane_data[15:0] !== 16'h1234 || sym_cnt !== 1'b1) begin
      failures++;
      $display("FAIL arst_pre: got v=%b d0=%h cnt=%h want v=01 d0=1234 cnt=1",
               lane_valid, lane_data[15:0], sym_cnt);
    end
    valid_in = 1'b0;
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({lane_data, lane_valid, lane_partial, overrun, sym_cnt} !== 38'd0) begin
      failures++;
      $display("FAIL arst_immediate: got data=%h v=%b cnt=%h want all 0",
               lane_data, lane_valid, sym_cnt);
    end
    @(negedge clk_4f);
    reset = 1'b1;
    drive(8'h5A, 1'b1, 1'b0, 2'b00);
    drive(8'hA5, 1'b1, 1'b0, 2'b00);
    checks++;
    if (lane_valid !== 2'b01 || lane_data[15:0] !== 16'h5AA5 || lane_partial !== 2'b00) begin
      failures++;
      $display("FAIL arst_after: got v=%b d0=%h p=%b want v=01 d0=5aa5 p=00",
               lane_valid, lane_data[15:0], lane_partial);
    end
  endtask

  task automatic test_same_edge;
    logic [7:0] bytes [6];
    logic [0:0] rdy   [6];
    logic [15:0] exp_d [6];
    bytes = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60};
    // Ready only on completion edges: lane reloads at the edge it is consumed
    rdy   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    exp_d = '{16'h0000, 16'h1020, 16'h1020, 16'h3040, 16'h3040, 16'h5060};
    for (int k = 0; k < 6; k++) begin
      drive1(bytes[k], 1'b1, rdy[k]);
      if (k > 0) begin
        checks++;
        if (d1_lane_valid !== 1'b1 || d1_lane_data !== exp_d[k] || d1_overrun !== 1'b0) begin
          failures++;
          $display("FAIL same_edge_k%0d: got v=%b d=%h ovr=%b want v=1 d=%h ovr=0",
                   k, d1_lane_valid, d1_lane_data, d1_overrun, exp_d[k]);
        end
      end
    end
    drive1(8'h00, 1'b0, 1'b1);
    checks++;
    if (d1_lane_valid !== 1'b0) begin
      failures++;
      $display("FAIL same_edge_drain: got v=%b want 0", d1_lane_valid);
    end
  endtask

  initial begin
    data_in = 8'h00; valid_in = 1'b0; sync_in = 1'b0; lane_ready = 2'b00;
    d1_data = 8'h00; d1_valid = 1'b0; d1_sync = 1'b0; d1_ready = 1'b0;
    @(negedge clk_4f);
    test_reset();
    test_basic();
    test_overrun();
    test_sync();
    test_flush();
    test_async_reset();
    test_same_edge();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
